// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter
// ---------------------------------------------------------------------------
// Shares one APB3 bus between two independent requesters.
//
// Each requester raises a simple valid/done request. The arbiter picks one
// round-robin, runs the APB SETUP and ACCESS phases toward the slave, and
// returns the read data and error status with a one-cycle done pulse.
//
// Optional feature (compile-time macro APB_ARB_TIMEOUT_EN):
//   When defined, a watchdog aborts an ACCESS phase after TIMEOUT_CYC cycles
//   with PREADY low. The aborted transfer completes with rq_err=1 and
//   rq_rdata=0. When undefined, ACCESS waits for PREADY indefinitely.
//
// Parameters:
//   ADDR_W       APB address width
//   DATA_W       APB data width
//   TIMEOUT_CYC  ACCESS wait budget (used only with APB_ARB_TIMEOUT_EN)
//
// Ports:
//   PCLK, PRESETn   clock; asynchronous active-low reset
//   rq_valid[1:0]   request pending, per requester
//   rq_write[1:0]   1 = write, 0 = read, per requester
//   rq_addr[i]      request address, per requester
//   rq_wdata[i]     write data, per requester
//   rq_done[1:0]    one-cycle completion pulse, per requester
//   rq_rdata        read data of the completed transfer (0 for writes)
//   rq_err          PSLVERR (or timeout) of the completed transfer
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA   APB master outputs (registered)
//   PRDATA, PREADY, PSLVERR                APB slave responses
// ---------------------------------------------------------------------------
module apb_req_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                   PCLK,
  input  logic                   PRESETn,
  input  logic [1:0]             rq_valid,
  input  logic [1:0]             rq_write,
  input  logic [1:0][ADDR_W-1:0] rq_addr,
  input  logic [1:0][DATA_W-1:0] rq_wdata,
  output logic [1:0]             rq_done,
  output logic [DATA_W-1:0]      rq_rdata,
  output logic                   rq_err,
  output logic                   PSEL,
  output logic                   PENABLE,
  output logic                   PWRITE,
  output logic [ADDR_W-1:0]      PADDR,
  output logic [DATA_W-1:0]      PWDATA,
  input  logic [DATA_W-1:0]      PRDATA,
  input  logic                   PREADY,
  input  logic                   PSLVERR
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  // A zero wait budget would abort every transfer on its first ACCESS
  // cycle; this guard block documents that TIMEOUT_CYC must be at least 1.
  if (TIMEOUT_CYC < 1) begin : g_timeout_cfg_invalid
  end

  state_t              state_q,   state_d;
  logic                last_q,    last_d;     // requester granted most recently
  logic                gnt_q,     gnt_d;      // requester owning the bus now
  logic                psel_q,    psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q,  pwrite_d;
  logic [ADDR_W-1:0]   paddr_q,   paddr_d;
  logic [DATA_W-1:0]   pwdata_q,  pwdata_d;
  logic [1:0]          done_q,    done_d;
  logic [DATA_W-1:0]   rdata_q,   rdata_d;
  logic                err_q,     err_d;

  logic [1:0]          eligible;
  logic                pick;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0]    tmo_cnt_q, tmo_cnt_d;
`endif

  // A requester whose done pulse is showing has not yet had a chance to
  // drop its valid, so it is masked for that one cycle.
  assign eligible = rq_valid & ~done_q;
  // Tie goes to whoever did not win last time; otherwise the lone requester.
  assign pick     = (eligible == 2'b11) ? ~last_q : eligible[1];

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    done_d    = 2'b00;        // done is a single-cycle pulse
    rdata_d   = rdata_q;
    err_d     = err_q;
`ifdef APB_ARB_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (|eligible) begin
          gnt_d    = pick;
          last_d   = pick;
          pwrite_d = rq_write[pick];
          paddr_d  = rq_addr[pick];
          pwdata_d = rq_wdata[pick];
          psel_d   = 1'b1;
          state_d  = ST_SETUP;
        end
      end

      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
      end

      ST_ACCESS: begin
        if (PREADY) begin
          done_d[gnt_q] = 1'b1;
          err_d         = PSLVERR;
          rdata_d       = pwrite_q ? '0 : PRDATA;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          state_d       = ST_IDLE;
        end
`ifdef APB_ARB_TIMEOUT_EN
        // This cycle would be the TIMEOUT_CYC-th with PREADY low: give up.
        else if (tmo_cnt_q == TMO_LAST) begin
          done_d[gnt_q] = 1'b1;
          err_d         = 1'b1;
          rdata_d       = '0;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          state_d       = ST_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end

      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= ST_IDLE;
      last_q    <= 1'b1;      // requester 0 wins the first tie
      gnt_q     <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      done_q    <= 2'b00;
      rdata_q   <= '0;
      err_q     <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
      tmo_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
`ifdef APB_ARB_TIMEOUT_EN
      tmo_cnt_q <= tmo_cnt_d;
`endif
    end
  end

  assign PSEL     = psel_q;
  assign PENABLE  = penable_q;
  assign PWRITE   = pwrite_q;
  assign PADDR    = paddr_q;
  assign PWDATA   = pwdata_q;
  assign rq_done  = done_q;
  assign rq_rdata = rdata_q;
  assign rq_err   = err_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter
// Self-checking bench for apb_req_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked each cycle against a
// transaction-level model of the arbiter kept in this file.
module tb_apb_req_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic                PCLK    = 1'b0;
  logic                PRESETn = 1'b1;
  logic [1:0]          rq_valid = 2'b00;
  logic [1:0]          rq_write = 2'b00;
  logic [1:0][AW-1:0]  rq_addr  = '0;
  logic [1:0][DW-1:0]  rq_wdata = '0;
  logic [1:0]          rq_done;
  logic [DW-1:0]       rq_rdata;
  logic                rq_err;
  logic                PSEL, PENABLE, PWRITE;
  logic [AW-1:0]       PADDR;
  logic [DW-1:0]       PWDATA;
  logic [DW-1:0]       PRDATA;
  logic                PREADY  = 1'b1;
  logic                PSLVERR = 1'b0;

  int n_pass  = 0;
  int n_total = 0;

  apb_req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .rq_valid(rq_valid), .rq_write(rq_write), .rq_addr(rq_addr), .rq_wdata(rq_wdata),
    .rq_done(rq_done), .rq_rdata(rq_rdata), .rq_err(rq_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  function automatic logic [DW-1:0] init_word(input int i);
    return (i == 3) ? 32'h4D61_6B73 : (32'hA500_0000 | DW'(i));   // word 3 holds "Maks"
  endfunction

  // Slave memory: 16 words, reinitialized while reset is held; stores on a
  // completed write (even if the slave flags PSLVERR).
  logic [DW-1:0] mem [16];
  assign PRDATA = mem[PADDR[5:2]];
  always @(posedge PCLK) begin
    if (!PRESETn) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
    end else if (PSEL && PENABLE && PREADY && PWRITE) begin
      mem[PADDR[5:2]] <= PWDATA;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // ---------------------------------------------------------------------
  // Reference model: tracks the transfer in flight as "granted at edge k",
  // with the bus selected from the grant until completion and the enable
  // phase starting one cycle after the grant.
  // ---------------------------------------------------------------------
  logic           m_busy, m_g, m_last, m_write, m_err;
  int             m_age, m_waits;
  logic [1:0]     m_done;
  logic [AW-1:0]  m_addr;
  logic [DW-1:0]  m_wdata, m_rdata;
  logic [DW-1:0]  shadow [16];

  always @(posedge PCLK or negedge PRESETn) begin
    logic [1:0] want;
    logic [1:0] fresh;
    if (!PRESETn) begin
      m_busy = 0; m_g = 0; m_last = 1; m_write = 0; m_err = 0;
      m_age = 0; m_waits = 0; m_done = 0;
      m_addr = '0; m_wdata = '0; m_rdata = '0;
      for (int i = 0; i < 16; i++) shadow[i] = init_word(i);
    end else begin
      fresh = 2'b00;
      if (!m_busy) begin
        want = rq_valid & ~m_done;
        if (want != 2'b00) begin
          if (want == 2'b11) m_g = !m_last;
          else               m_g = want[1];
          m_last  = m_g;
          m_write = rq_write[m_g];
          m_addr  = rq_addr[m_g];
          m_wdata = rq_wdata[m_g];
          m_busy  = 1;
          m_age   = 0;
          m_waits = 0;
        end
      end else if (m_age == 0) begin
        m_age = 1;
      end else if (PREADY) begin
        fresh[m_g] = 1'b1;
        m_err = PSLVERR;
        if (m_write) begin
          shadow[m_addr[5:2]] = m_wdata;
          m_rdata = '0;
        end else begin
          m_rdata = shadow[m_addr[5:2]];
        end
        m_busy = 0;
      end else begin
        m_waits++;
`ifdef APB_ARB_TIMEOUT_EN
        if (m_waits == TO) begin
          fresh[m_g] = 1'b1;
          m_err = 1;
          m_rdata = '0;
          m_busy = 0;
        end
`endif
      end
      m_done = fresh;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge PCLK) begin
    if (PRESETn) begin
      chk("psel",    64'(PSEL),     64'(m_busy));
      chk("penable", 64'(PENABLE),  64'(m_busy && m_age >= 1));
      chk("pwrite",  64'(PWRITE),   64'(m_write));
      chk("paddr",   64'(PADDR),    64'(m_addr));
      chk("pwdata",  64'(PWDATA),   64'(m_wdata));
      chk("done",    64'(rq_done),  64'(m_done));
      chk("rdata",   64'(rq_rdata), 64'(m_rdata));
      chk("err",     64'(rq_err),   64'(m_err));
    end
  end

  task automatic issue(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    rq_valid[i] = 1'b1;
    rq_write[i] = w;
    rq_addr[i]  = a;
    rq_wdata[i] = d;
  endtask

  // Counts negedges until a done pulse shows; bounded.
  task automatic wait_done(output logic [1:0] d, output int n);
    d = 2'b00;
    n = 0;
    while (n < 64 && d == 2'b00) begin
      @(negedge PCLK);
      n++;
      d = rq_done;
    end
    if (d == 2'b00) chk("done_timeout", 64'(0), 64'(1));
  endtask

  logic [1:0] d;
  int         n;
  logic [1:0] drop_pend;

  initial begin
    #1 PRESETn = 1'b0;
    repeat (3) @(negedge PCLK);
    PRESETn = 1'b1;

    // Reset state
    chk("rst_psel",  64'(PSEL),     64'(0));
    chk("rst_paddr", 64'(PADDR),    64'(0));
    chk("rst_done",  64'(rq_done),  64'(0));
    chk("rst_rdata", 64'(rq_rdata), 64'(0));

    // Contention: both held valid; rq0 first, then strict alternation
    issue(0, 1'b0, 32'h4, '0);
    issue(1, 1'b0, 32'h8, '0);
    for (int k = 0; k < 4; k++) begin
      wait_done(d, n);
      chk("cont_who", 64'(d), (k % 2 == 0) ? 64'h1 : 64'h2);
      chk("cont_lat", 64'(n), 64'(3));
      chk("cont_rd",  64'(rq_rdata), (k % 2 == 0) ? 64'hA500_0001 : 64'hA500_0002);
    end
    rq_valid = 2'b00;
    @(negedge PCLK);

    // Single write then read back
    issue(0, 1'b1, 32'h0, 32'd9);
    wait_done(d, n);
    rq_valid = 2'b00;
    chk("wr_who", 64'(d), 64'h1);
    chk("wr_lat", 64'(n), 64'(3));
    chk("wr_err", 64'(rq_err), 64'(0));
    chk("wr_rd0", 64'(rq_rdata), 64'(0));
    @(negedge PCLK);
    issue(0, 1'b0, 32'h0, '0);
    wait_done(d, n);
    rq_valid = 2'b00;
    chk("rd_who",  64'(d), 64'h1);
    chk("rd_data", 64'(rq_rdata), 64'(9));
    @(negedge PCLK);

    // Three wait states on read of 0xC
    PREADY = 1'b0;
    issue(0, 1'b0, 32'hC, '0);
    n = 0;
    d = 2'b00;
    while (n < 20 && d == 2'b00) begin
      @(negedge PCLK);
      n++;
      if (n == 5) PREADY = 1'b1;
      d = rq_done;
    end
    rq_valid = 2'b00;
    chk("ws_who",  64'(d), 64'h1);
    chk("ws_lat",  64'(n), 64'(6));
    chk("ws_data", 64'(rq_rdata), 64'h4D61_6B73);
    @(negedge PCLK);

    // Slave error on one transfer only
    PSLVERR = 1'b1;
    issue(1, 1'b1, 32'h10, 32'h55);
    wait_done(d, n);
    rq_valid = 2'b00;
    PSLVERR = 1'b0;
    chk("se_who", 64'(d), 64'h2);
    chk("se_err", 64'(rq_err), 64'(1));
    @(negedge PCLK);
    issue(1, 1'b0, 32'h10, '0);
    wait_done(d, n);
    rq_valid = 2'b00;
    chk("se_next_err", 64'(rq_err), 64'(0));
    chk("se_next_rd",  64'(rq_rdata), 64'h55);
    @(negedge PCLK);

`ifdef APB_ARB_TIMEOUT_EN
    // Stuck slave: abort after TO ACCESS cycles
    PREADY = 1'b0;
    issue(0, 1'b0, 32'h0, '0);
    wait_done(d, n);
    rq_valid = 2'b00;
    chk("to_who",   64'(d), 64'h1);
    chk("to_lat",   64'(n), 64'(2 + TO));
    chk("to_err",   64'(rq_err), 64'(1));
    chk("to_rdata", 64'(rq_rdata), 64'(0));
    chk("to_psel",  64'(PSEL), 64'(0));
    PREADY = 1'b1;
    @(negedge PCLK);
`endif

    // Reset during ACCESS
    PREADY = 1'b0;
    issue(0, 1'b0, 32'h4, '0);
    repeat (2) @(negedge PCLK);
    chk("ra_in_access", 64'(PENABLE), 64'(1));
    #2 PRESETn = 1'b0;
    #1;
    chk("ra_psel",    64'(PSEL),    64'(0));
    chk("ra_penable", 64'(PENABLE), 64'(0));
    rq_valid = 2'b00;
    PREADY = 1'b1;
    repeat (2) @(negedge PCLK);
    chk("ra_nodone", 64'(rq_done), 64'(0));
    PRESETn = 1'b1;
    issue(1, 1'b0, 32'h8, '0);
    wait_done(d, n);
    rq_valid = 2'b00;
    chk("ra_who",  64'(d), 64'h2);
    chk("ra_lat",  64'(n), 64'(3));
    chk("ra_data", 64'(rq_rdata), 64'hA500_0002);
    @(negedge PCLK);

    // Randomized traffic: requesters hold valid through the done cycle and
    // drop it one cycle later; occasional withdrawal before grant.
    drop_pend = 2'b00;
    for (int c = 0; c < 3000; c++) begin
      @(negedge PCLK);
      PREADY  = ($urandom_range(3) != 0);
      PSLVERR = ($urandom_range(7) == 0);
      for (int i = 0; i < 2; i++) begin
        if (drop_pend[i]) begin
          rq_valid[i]  = 1'b0;
          drop_pend[i] = 1'b0;
        end else if (rq_valid[i] && m_done[i]) begin
          drop_pend[i] = 1'b1;
        end else if (rq_valid[i] && !(m_busy && m_g == i) && $urandom_range(15) == 0) begin
          rq_valid[i] = 1'b0;
        end else if (!rq_valid[i] && $urandom_range(3) == 0) begin
          logic [AW-1:0] a;
          a = AW'($urandom);
          a[1:0] = 2'b00;
          issue(i, 1'($urandom_range(1)), a, DW'($urandom));
        end
      end
    end
    rq_valid = 2'b00;
    PREADY = 1'b1;
    repeat (6) @(negedge PCLK);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/apb_req_arbiter.md
# apb_req_arbiter

Two-port APB master front end that shares a single APB3 bus between two independent requesters (e.g. the testbench master model and a DMA/config sequencer). It accepts simple valid/done requests, arbitrates round-robin, and sequences the APB SETUP/ACCESS phases toward the slave (`apb_slave` on `slave_mp`). Read data and error status are returned to the granted requester with a one-cycle done pulse.

## Interface
- `ADDR_W`, 32, APB address width
- `DATA_W`, 32, APB data width
- `TIMEOUT_CYC`, 16, max ACCESS cycles waiting for PREADY (used only with `APB_ARB_TIMEOUT_EN`)

- `PCLK`  in  1  clock; single clock domain
- `PRESETn`  in  1  reset, asynchronous, active-low
- `rq_valid`  in  [1:0]  request pending, per requester
- `rq_write`  in  [1:0]  1 = write, 0 = read, per requester
- `rq_addr`  in  [1:0][ADDR_W-1:0]  request address
- `rq_wdata`  in  [1:0][DATA_W-1:0]  write data
- `rq_done`  out  [1:0]  one-cycle completion pulse, per requester
- `rq_rdata`  out  DATA_W  read data of completed transfer (shared)
- `rq_err`  out  1  PSLVERR (or timeout) of completed transfer
- `PSEL`, `PENABLE`, `PWRITE`  out  1  APB control
- `PADDR`  out  ADDR_W;  `PWDATA`  out  DATA_W
- `PRDATA`  in  DATA_W;  `PREADY`, `PSLVERR`  in  1

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: if any eligible `rq_valid`, pick grant `g`; latch `rq_write[g]`, `rq_addr[g]`, `rq_wdata[g]` into PWRITE/PADDR/PWDATA; next SETUP.
- Round-robin: `last` register; both valid -> grant `~last`; one valid -> that one. `last <= g` on grant. Reset value `last = 1` (requester 0 wins first tie).
- Eligibility: `rq_valid[i]` ignored in the cycle `rq_done[i]=1` (requester drops valid on seeing done; no duplicate issue).
- SETUP: PSEL=1, PENABLE=0; unconditionally -> ACCESS.
- ACCESS: PSEL=1, PENABLE=1; hold while PREADY=0. On PREADY=1: register `rq_done[g]=1`, `rq_err=PSLVERR`, `rq_rdata = PWRITE ? 0 : PRDATA`; PSEL/PENABLE drop; -> IDLE.
- PADDR/PWRITE/PWDATA stable from SETUP through last ACCESS cycle; retain value in IDLE.
- Withdrawing `rq_valid` before grant cancels cleanly; after grant, request is committed regardless of `rq_valid`.
- `rq_rdata`/`rq_err` valid only while `rq_done` high; held until next completion.

## Timing
- Reset (async assert, sync release): state IDLE, PSEL=PENABLE=PWRITE=0, PADDR=PWDATA=0, `rq_done=0`, `rq_rdata=0`, `rq_err=0`, `last=1`.
- Reset mid-transfer: PSEL/PENABLE drop immediately; no `rq_done` issued.
- Valid sampled in IDLE at edge N -> SETUP cycle N+1, ACCESS N+2.
- Zero-wait slave: `rq_done` in cycle N+3; 3 cycles per transfer; one mandatory IDLE cycle between transfers (no back-to-back SETUP).
- Each PREADY wait cycle adds exactly one cycle of latency.
- Both requesters continuously valid: grants strictly alternate, one transfer each per 3 cycles (zero-wait).

## Configuration
- `APB_ARB_TIMEOUT_EN` defined: counter cleared on entering ACCESS, increments each ACCESS cycle with PREADY=0; when it reaches `TIMEOUT_CYC` with PREADY still 0, transfer is aborted: `rq_done[g]=1`, `rq_err=1`, `rq_rdata=0`, PSEL/PENABLE drop, -> IDLE. PREADY=1 in the same cycle as expiry wins (normal completion).
- Not defined: counter absent; ACCESS waits for PREADY indefinitely; `rq_err` reflects only PSLVERR.

## Test plan
- Single write: rq0 write addr 0x0 data 9 -> PSEL at N+1, PENABLE at N+2, `rq_done[0]` at N+3, `rq_err=0`; read back 0x0 -> `rq_rdata=9`.
- Contention: rq0 and rq1 valid together after reset (rq0 read 0x4, rq1 read 0x8) -> rq0 granted first, rq1 next; grants alternate over 4 held requests.
- Wait states: slave holds PREADY low 3 cycles on read 0xC ("Maks") -> PADDR/PSEL stable, `rq_done[0]` 3 cycles later than zero-wait, `rq_rdata="Maks"`.
- Slave error: PSLVERR=1 with PREADY -> `rq_err=1` for that done pulse only; next transfer `rq_err=0`.
- Reset during ACCESS: PRESETn low -> PSEL/PENABLE 0 asynchronously, no done; after release rq1 valid -> normal transfer.
- With `APB_ARB_TIMEOUT_EN`, TIMEOUT_CYC=4, PREADY stuck 0 -> done after 4 ACCESS cycles, `rq_err=1`, `rq_rdata=0`, FSM back in IDLE.
